// File: rtl/alu_control.sv
// rtl/alu_control.sv - registered funct decoder feeding ALU/Shifter/Multiplier/MUX
// Sequences multi-cycle MULTU with a busy flag and a one-cycle HiLo write strobe.
module alu_control #(
  parameter int CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Signal,
  output logic [5:0] SignaltoALU,
  output logic [5:0] SignaltoSHT,
  output logic [5:0] SignaltoMULT,
  output logic [5:0] SignaltoMUX,
  output logic       hilo_we,
  output logic       busy
);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  // hilo_we is registered, so it is raised one edge early to be high while cnt == LAST
  localparam logic [4:0] LAST = 5'(CYCLES - 1);
  localparam logic [4:0] PRE  = 5'(CYCLES - 2);

  typedef enum logic {IDLE, MULT} state_t;

  state_t     state, state_n;
  logic [4:0] cnt, cnt_n;
  logic [5:0] alu_n, sht_n, mult_n, mux_n;
  logic       we_n, busy_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      SignaltoALU  <= '0;
      SignaltoSHT  <= '0;
      SignaltoMULT <= '0;
      SignaltoMUX  <= '0;
      hilo_we      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      SignaltoALU  <= alu_n;
      SignaltoSHT  <= sht_n;
      SignaltoMULT <= mult_n;
      SignaltoMUX  <= mux_n;
      hilo_we      <= we_n;
      busy         <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    alu_n   = '0;
    sht_n   = '0;
    mult_n  = '0;
    mux_n   = '0;
    we_n    = 1'b0;
    busy_n  = 1'b0;
    case (state)
      IDLE: begin
        case (Signal)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
            alu_n = Signal;
            mux_n = Signal;
          end
          F_SRL: begin
            sht_n = F_SRL;
            mux_n = F_SRL;
          end
          F_MFHI, F_MFLO: mux_n = Signal;
          F_MULTU: begin
            state_n = MULT;
            cnt_n   = '0;
            mult_n  = F_MULTU;
            busy_n  = 1'b1;
          end
          default: ;
        endcase
      end
      MULT: begin
        // Signal is deliberately not looked at here, including on the exit edge
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n  = cnt + 5'd1;
          mult_n = F_MULTU;
          busy_n = 1'b1;
          we_n   = (cnt == PRE);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_control.sv
// tb/tb_alu_control.sv - scoreboard bench for alu_control
// Driver queues the expected post-edge outputs; monitor pops and compares every cycle.
module tb_alu_control;

  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100;
  localparam logic [5:0] OR_ = 6'b100101, SLT = 6'b101010, SRL = 6'b000010;
  localparam logic [5:0] MULTU = 6'b011001, MFHI = 6'b010000, MFLO = 6'b010010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Signal = 6'd0;
  logic [5:0] SignaltoALU, SignaltoSHT, SignaltoMULT, SignaltoMUX;
  logic       hilo_we, busy;

  typedef struct {
    string       name;
    logic [25:0] exp;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;

  alu_control #(.CYCLES(32)) dut (
    .clk(clk), .reset(reset), .Signal(Signal),
    .SignaltoALU(SignaltoALU), .SignaltoSHT(SignaltoSHT),
    .SignaltoMULT(SignaltoMULT), .SignaltoMUX(SignaltoMUX),
    .hilo_we(hilo_we), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] mk(logic [5:0] a, logic [5:0] s, logic [5:0] m,
                                     logic [5:0] x, logic w, logic b);
    return {a, s, m, x, w, b};
  endfunction

  // drive inputs for the next edge and queue the outputs expected right after it
  task automatic step(input logic r, input logic [5:0] s, input string nm,
                      input logic [25:0] e);
    @(negedge clk);
    reset  = r;
    Signal = s;
    q.push_back('{name: nm, exp: e});
  endtask

  initial begin : monitor
    item_t       it;
    logic [25:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        it  = q.pop_front();
        got = {SignaltoALU, SignaltoSHT, SignaltoMULT, SignaltoMUX, hilo_we, busy};
        checks++;
        if (got !== it.exp) begin
          errors++;
          $display("FAIL %s: got alu=%b sht=%b mult=%b mux=%b we=%b busy=%b, expected alu=%b sht=%b mult=%b mux=%b we=%b busy=%b",
                   it.name, got[25:20], got[19:14], got[13:8], got[7:2], got[1], got[0],
                   it.exp[25:20], it.exp[19:14], it.exp[13:8], it.exp[7:2], it.exp[1], it.exp[0]);
        end
      end
    end
  end

  initial begin : driver
    logic [25:0] z, mb;
    z  = mk(0, 0, 0, 0, 0, 0);
    mb = mk(0, 0, MULTU, 0, 0, 1);

    // reset sequence
    step(1, ADD, "reset0", z);
    step(1, ADD, "reset1", z);
    step(0, ADD, "add_after_reset", mk(ADD, 0, 0, ADD, 0, 0));

    // back-to-back single-cycle decode
    step(0, SRL,      "srl",    mk(0, SRL, 0, SRL, 0, 0));
    step(0, MFLO,     "mflo",   mk(0, 0, 0, MFLO, 0, 0));
    step(0, 6'h3f,    "ill3f",  z);
    step(0, SUB,      "sub",    mk(SUB, 0, 0, SUB, 0, 0));
    step(0, AND_,     "and",    mk(AND_, 0, 0, AND_, 0, 0));
    step(0, OR_,      "or",     mk(OR_, 0, 0, OR_, 0, 0));
    step(0, SLT,      "slt",    mk(SLT, 0, 0, SLT, 0, 0));
    step(0, MFHI,     "mfhi",   mk(0, 0, 0, MFHI, 0, 0));
    step(0, 6'h00,    "nop",    z);
    step(0, 6'b000011,"ill03",  z);

    // MULTU with ADD held during busy: ADD appears in cycle 34
    step(0, MULTU, "m1_c1", mb);
    for (int c = 1; c <= 31; c++)
      step(0, ADD, $sformatf("m1_c%0d", c + 1), (c + 1 == 32) ? mk(0, 0, MULTU, 0, 1, 1) : mb);
    step(0, ADD, "m1_c33", z);
    step(0, ADD, "m1_c34", mk(ADD, 0, 0, ADD, 0, 0));

    // second MULTU at cycle 5 ignored; MULTU on exit edge also not decoded
    step(0, MULTU, "m2_c1", mb);
    for (int c = 1; c <= 31; c++)
      step(0, (c == 5) ? MULTU : 6'h00, $sformatf("m2_c%0d", c + 1),
           (c + 1 == 32) ? mk(0, 0, MULTU, 0, 1, 1) : mb);
    step(0, MULTU, "m2_c33", z);
    step(0, 6'h00, "m2_c34", z);

    // reset in cycle 10 of a MULTU aborts without a strobe
    step(0, MULTU, "m3_c1", mb);
    for (int c = 1; c <= 9; c++)
      step(0, 6'h00, $sformatf("m3_c%0d", c + 1), mb);
    step(1, 6'h00, "m3_reset_c11", z);
    for (int c = 11; c <= 40; c++)
      step(0, 6'h00, $sformatf("m3_c%0d", c + 1), z);
    step(0, SRL, "m3_srl_after", mk(0, SRL, 0, SRL, 0, 0));
    step(0, 6'h00, "final_nop", z);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
